// File: rtl/axis_wave_gen.sv
// axis_wave_gen: AXI4-Stream sine/square/sawtooth/DC test-waveform source
// with sample repetition, attenuation and fixed-length tlast framing.
module axis_wave_gen #(
   parameter int DATA_W    = 16,
   parameter int PH_W      = 3,
   parameter int FRAME_LEN = 64,
   parameter int HOLD_W    = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic [1:0]          mode,
   input  logic [HOLD_W-1:0]   hold,
   input  logic [3:0]          shift,
   input  logic [DATA_W-1:0]   dc_level,
   output logic [DATA_W-1:0]   m_axis_tdata,
   output logic                m_axis_tvalid,
   input  logic                m_axis_tready,
   output logic                m_axis_tlast,
   output logic [DATA_W/8-1:0] m_axis_tkeep,
   output logic                busy,
   output logic [15:0]         frame_count
);
   localparam int N = 2 ** PH_W;
   localparam int BW = $clog2(FRAME_LEN);
   localparam logic [BW-1:0] LAST = BW'(FRAME_LEN - 1);
   localparam logic [DATA_W-1:0] POS_M = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic [DATA_W-1:0] NEG_M = {1'b1, {(DATA_W-2){1'b0}}, 1'b1};
   localparam real PI = 3.14159265358979323846;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   function automatic int sine_val(input int p);
      real v;
      v = ((2.0 ** (DATA_W - 1)) - 1.0) * $sin(2.0 * PI * p / N);
      return v < 0.0 ? -$rtoi(0.5 - v) : $rtoi(v + 0.5);
   endfunction

   logic [DATA_W-1:0] sine_rom [N];
   for (genvar i = 0; i < N; i++) begin : g_sine
      assign sine_rom[i] = DATA_W'(sine_val(i));
   end

   state_t            state, state_n;
   logic [1:0]        cfg_mode, mode_n;
   logic [HOLD_W-1:0] cfg_hold, hold_n, hold_cnt, hold_cnt_n;
   logic [3:0]        cfg_shift, shift_n;
   logic [DATA_W-1:0] cfg_dc, dc_n, raw, data_n;
   logic [PH_W-1:0]   phase, phase_n;
   logic [BW-1:0]     beat_cnt, beat_n;
   logic              xfer, end_frame, use_in, step, valid_n, last_n;

   assign m_axis_tkeep = '1;
   assign busy = state != IDLE;

   always_comb begin
      xfer = m_axis_tvalid && m_axis_tready;
      end_frame = xfer && m_axis_tlast;
      // configuration is only sampled when starting or at a frame boundary
      use_in = state == IDLE || end_frame;
      mode_n = use_in ? mode : cfg_mode;
      hold_n = use_in ? hold : cfg_hold;
      shift_n = use_in ? shift : cfg_shift;
      dc_n = use_in ? dc_level : cfg_dc;
      step = hold_cnt == cfg_hold;
      phase_n = state == IDLE ? '0 : (xfer && step) ? phase + 1'b1 : phase;
      hold_cnt_n = (state == IDLE || (xfer && step)) ? '0 : xfer ? hold_cnt + 1'b1 : hold_cnt;
      beat_n = (state == IDLE || end_frame) ? '0 : xfer ? beat_cnt + 1'b1 : beat_cnt;
      valid_n = use_in ? enable : 1'b1;
      state_n = !valid_n ? IDLE : enable ? RUN : DRAIN;
      raw = mode_n == 2'd0 ? sine_rom[phase_n] :
            mode_n == 2'd1 ? (phase_n[PH_W-1] ? NEG_M : POS_M) :
            mode_n == 2'd2 ? DATA_W'({~phase_n[PH_W-1], phase_n[PH_W-2:0]}) << (DATA_W - PH_W) :
            dc_n;
      data_n = ((state == IDLE && enable) || xfer) ? DATA_W'($signed(raw) >>> shift_n) : m_axis_tdata;
      last_n = beat_n == LAST;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
         cfg_mode <= '0;
         cfg_hold <= '0;
         cfg_shift <= '0;
         cfg_dc <= '0;
         phase <= '0;
         hold_cnt <= '0;
         beat_cnt <= '0;
         m_axis_tdata <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast <= 1'b0;
         frame_count <= '0;
      end else begin
         state <= state_n;
         cfg_mode <= mode_n;
         cfg_hold <= hold_n;
         cfg_shift <= shift_n;
         cfg_dc <= dc_n;
         phase <= phase_n;
         hold_cnt <= hold_cnt_n;
         beat_cnt <= beat_n;
         m_axis_tdata <= data_n;
         m_axis_tvalid <= valid_n;
         m_axis_tlast <= last_n;
         frame_count <= frame_count + 16'(end_frame);
      end
   end
endmodule

// File: doc/axis_wave_gen.md
# axis_wave_gen

Parametrised AXI4-Stream test-waveform source: emits sine, square, sawtooth or DC samples from a phase accumulator, with programmable sample repetition, amplitude attenuation and fixed-length framing (tlast). It replaces hand-coded per-sample stimulus state machines in FIR/DSP benches and on-chip self-test paths, driving the slave stream input of the block under test.

## Interface
- DATA_W, 16: sample width, two's complement; multiple of 8, 8..32.
- PH_W, 3: phase bits; table length N = 2^PH_W, 3..8.
- FRAME_LEN, 64: beats per frame, >=2.
- HOLD_W, 8: width of hold field.
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- enable  in  1  run request, level-sensitive.
- mode  in  2  0 sine, 1 square, 2 sawtooth, 3 DC.
- hold  in  HOLD_W  each phase point emitted hold+1 beats.
- shift  in  4  arithmetic right-shift applied to sample (attenuation).
- dc_level  in  DATA_W  sample value in mode 3.
- m_axis_tdata  out  DATA_W  sample.
- m_axis_tvalid  out  1  sample valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last beat of frame.
- m_axis_tkeep  out  DATA_W/8  constant all ones.
- busy  out  1  state != IDLE.
- frame_count  out  16  frames completed since reset, wraps at 0xFFFF->0.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: tvalid=0. enable=1 -> latch mode/hold/shift/dc_level into config registers, phase=0, hold_cnt=0, beat_cnt=0, load beat 0 into output register, go RUN.
- RUN: a beat transfers when tvalid&tready. On transfer: beat_cnt++; if hold_cnt==hold then hold_cnt=0, phase++ (wraps N-1->0) else hold_cnt++; next sample loaded same edge, tvalid stays 1.
- enable low in RUN -> DRAIN; frame always completes. DRAIN behaves as RUN; enable re-asserted in DRAIN returns to RUN.
- Transfer with tlast=1: frame_count++, beat_cnt=0; config re-latched from inputs (config changes only at frame boundaries). Phase and hold_cnt continue (not reset) across frames. From DRAIN: go IDLE, tvalid=0 next cycle. From RUN: stay RUN, next beat presented immediately.
- tlast = (beat_cnt == FRAME_LEN-1) for the presented beat.
- Sample generation (before shift), M = 2^(DATA_W-1)-1:
  - sine: table[phase] = round(M*sin(2*pi*phase/N)), computed at elaboration.
  - square: +M for phase < N/2, -M otherwise.
  - sawtooth: phase << (DATA_W-PH_W) with MSB inverted (i.e. -2^(DATA_W-1) + phase*2^DATA_W/N).
  - DC: dc_level.
- Output = sample >>> shift (sign-extending); shift >= DATA_W gives 0 or -1 per sign.

## Timing
- Reset (reset=0 at rising edge): state IDLE, tvalid=0, tlast=0, tdata=0, busy=0, frame_count=0, all counters 0; takes priority over every other event, including mid-frame (frame abandoned, no tlast).
- Latency: enable sampled high in IDLE at edge k -> tvalid=1 with phase-0 sample after edge k.
- Output registered; while tvalid=1 and tready=0, tdata/tlast/tvalid held stable (AXI rule); tvalid never drops without a transfer.
- Throughput: one beat per cycle when tready=1.
- Simultaneous tlast transfer and enable fall: goes IDLE (falling in RUN at that edge treated as DRAIN completing).
- enable toggling mid-frame without tlast: no effect on data or beat_cnt.

## Test plan
- DATA_W=16, PH_W=3, hold=0, shift=0, sine, tready=1: beats 0,23170,32767,23170,0,-23170,-32767,-23170 repeating; tvalid one cycle after enable.
- Square, hold=1: 32767 x8 then -32767 x8; sawtooth hold=0: -32768,-24576,...,24576; shift=2 on sine gives 0,5792,8191,5792,0,-5793,-8192,-5793.
- FRAME_LEN=64, tready=1: tlast on beats 63,127; frame_count 1,2; mode changed mid-frame takes effect only on beat 64.
- tready random 50%: every accepted sequence identical to tready=1 sequence; tdata stable during every stall.
- enable dropped at beat 10: beats 10..63 still delivered, tlast on 63, tvalid=0 next cycle, busy=0, frame_count+1.
- reset=0 asserted at beat 30: next cycle tvalid=0, tdata=0, frame_count=0; re-enable restarts from phase 0, beat 0.
